pipeline_run_ctrl: RTL and testbench
====================================

# pipeline_run_ctrl

Run/step/halt sequencer for the 5-stage pipelined CPU. It sits beside `CPU` and drives a single pipeline-advance enable (`run_o`) that gates the PC and all pipeline registers. It counts executed cycles, hazard stalls and IF/ID flushes in hardware, and stops the pipeline on request or when a configurable cycle budget is used up. It replaces ad-hoc counting in benches and gives a debug host single-step control.

## Interface
- `CNT_W`, 32: width of each counter.
- `MAX_CYCLES`, 30: advance-cycle budget before automatic halt; 0 = unlimited.

Ports:
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  synchronous, active-low reset.
- `start_i`  in  1  level; begin or resume free-running execution.
- `step_i`  in  1  level; execute exactly one advance cycle.
- `halt_req_i`  in  1  level; stop free-running execution.
- `clear_i`  in  1  return to IDLE and zero the counters; honoured only in HALT.
- `stall_i`  in  1  hazard-detection stall indication for the current cycle.
- `flush_i`  in  1  IF/ID flush indication for the current cycle.
- `run_o`  out  1  pipeline advance enable.
- `state_o`  out  2  current state encoding.
- `done_o`  out  1  one-cycle pulse on entry to HALT.
- `limit_o`  out  1  sticky flag: cycle budget reached.
- `cycle_cnt_o`  out  CNT_W  count of advance cycles.
- `stall_cnt_o`  out  CNT_W  count of advance cycles with `stall_i`=1.
- `flush_cnt_o`  out  CNT_W  count of advance cycles with `flush_i`=1.

## Operation
- States: IDLE=0, RUN=1, STEP=2, HALT=3. `run_o` = (state==RUN || state==STEP), decoded from the registered state.
- IDLE:
  - `start_i` → RUN.
  - else `step_i` → STEP.
  - `halt_req_i` and `clear_i` are ignored.
- RUN:
  - Go to HALT if `halt_req_i`=1, or if `MAX_CYCLES`≠0 and `cycle_cnt_o`==`MAX_CYCLES`-1 this cycle.
  - Otherwise stay in RUN.
- STEP → HALT unconditionally after its single cycle. `halt_req_i` has no extra effect.
- HALT, in priority order:
  - `clear_i` → IDLE and zero all counters and `limit_o`.
  - else if `limit_o`=1, stay in HALT.
  - else `start_i` → RUN.
  - else `step_i` → STEP.
- Counting, only in cycles with `run_o`=1:
  - `cycle_cnt_o`+1.
  - `stall_cnt_o`+1 if `stall_i`.
  - `flush_cnt_o`+1 if `flush_i`.
  - `stall_i`/`flush_i` are don't-care while `run_o`=0.
  - All counters saturate at 2^CNT_W−1; no wrap.
- `limit_o` sets in the same edge that takes RUN or STEP to HALT because the budget is reached. It is cleared only by reset or `clear_i`.
- `done_o` is high for exactly the first cycle in HALT, whether the cause is `halt_req_i`, the budget, or the end of a step.
- Simultaneous events:
  - `start_i`+`step_i` in IDLE/HALT → RUN.
  - `halt_req_i` and budget reached in the same cycle → HALT with `limit_o`=1.
  - A STEP whose cycle hits the budget → `limit_o`=1.

## Timing
- Reset: state IDLE, `run_o`=0, `done_o`=0, `limit_o`=0, all counters 0. Reset during RUN or STEP takes effect at the next edge and wins over every other input.
- Start latency: `start_i` sampled at edge N gives `run_o`=1 from cycle N+1.
- Halt latency:
  - The cycle in which `halt_req_i` is sampled still has `run_o`=1 and is counted.
  - `run_o`=0 and `done_o`=1 in the following cycle.
- Budget: from IDLE with `start_i` held, `run_o` is high for exactly `MAX_CYCLES` consecutive cycles. `cycle_cnt_o` then reads `MAX_CYCLES`.
- Counter outputs are registered and reflect all advance cycles up to the previous edge.

## Structure
- Shared package `cpu_ctrl_pkg`:
  - state enum `run_state_t` with the encodings above.
  - localparams `ST_IDLE`, `ST_RUN`, `ST_STEP`, `ST_HALT`.
- Sub-module `sat_counter`:
  - parameter `W`.
  - ports: `clk_i`, `rst_i`, `clr_i`, `inc_i`, `cnt_o`.
  - instantiated three times.
- Next-state logic and the flags stay in `pipeline_run_ctrl`.

## Test plan
- Budget run: `MAX_CYCLES`=30, `start_i` held, `stall_i`=1 on cycles 3 and 4, `flush_i`=1 on cycle 10 → `run_o` high exactly 30 cycles, then `cycle_cnt_o`=30, `stall_cnt_o`=2, `flush_cnt_o`=1, `limit_o`=1, one `done_o` pulse. A further `start_i` keeps HALT.
- Halt/resume: start, `halt_req_i` on 5th run cycle → `cycle_cnt_o`=5, HALT. `start_i` → RUN again, counts continue from 5.
- Single step: from IDLE, three `step_i` pulses separated by idle cycles → `cycle_cnt_o`=3, `run_o` high for exactly 3 isolated cycles, 3 `done_o` pulses.
- Masking and clear: `stall_i`=`flush_i`=1 throughout IDLE/HALT → counters unchanged. `clear_i` in HALT → IDLE, all counters 0, `limit_o`=0. `clear_i` in RUN → ignored.
- Saturation: `CNT_W`=3, `MAX_CYCLES`=0, run 10 cycles with `stall_i`=1 → `cycle_cnt_o`=`stall_cnt_o`=7.
- Reset mid-run: `rst_i`=0 for one edge during RUN with counters nonzero → next cycle IDLE, `run_o`=0, all outputs 0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU run/step/halt controller.
// State encodings are fixed because state_o is visible to the debug host.
package cpu_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STEP = 2'd2;
    localparam logic [1:0] ST_HALT = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_STEP = ST_STEP,
        S_HALT = ST_HALT
    } run_state_t;

endpackage

// File: rtl/pipeline_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low reset and synchronous clear.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_i || clr_i)
            r_cnt <= '0;
        else if (inc_i && (r_cnt != {W{1'b1}}))
            r_cnt <= r_cnt + 1'b1;
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Run/step/halt sequencer: drives the pipeline advance enable and counts
// advance cycles, stalls and flushes, halting on request or when the budget is used.
module pipeline_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 30
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             step_i,
    input  logic             halt_req_i,
    input  logic             clear_i,
    input  logic             stall_i,
    input  logic             flush_i,
    output logic             run_o,
    output logic [1:0]       state_o,
    output logic             done_o,
    output logic             limit_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(MAX_CYCLES - 1);

    run_state_t       r_state;
    run_state_t       w_next;
    logic             r_done;
    logic             r_limit;
    logic             w_run;
    logic             w_hit;
    logic             w_clr;
    logic [CNT_W-1:0] w_cycle_cnt;

    assign w_run = (r_state == S_RUN) || (r_state == S_STEP);
    // Budget is reached in the advance cycle that will make the count MAX_CYCLES.
    assign w_hit = (MAX_CYCLES != 0) && w_run && (w_cycle_cnt == LP_LAST);
    assign w_clr = (r_state == S_HALT) && clear_i;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i)     w_next = S_RUN;
                else if (step_i) w_next = S_STEP;
            end
            S_RUN: begin
                if (halt_req_i || w_hit) w_next = S_HALT;
            end
            S_STEP: w_next = S_HALT;
            S_HALT: begin
                if (clear_i)      w_next = S_IDLE;
                else if (r_limit) w_next = S_HALT;
                else if (start_i) w_next = S_RUN;
                else if (step_i)  w_next = S_STEP;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
            r_limit <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (w_next == S_HALT) && (r_state != S_HALT);
            if (w_clr)
                r_limit <= 1'b0;
            else if (w_hit)
                r_limit <= 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (w_clr),
        .inc_i (w_run),
        .cnt_o (w_cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (w_clr),
        .inc_i (w_run && stall_i),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (w_clr),
        .inc_i (w_run && flush_i),
        .cnt_o (flush_cnt_o)
    );

    assign run_o       = w_run;
    assign state_o     = r_state;
    assign done_o      = r_done;
    assign limit_o     = r_limit;
    assign cycle_cnt_o = w_cycle_cnt;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Self-checking bench for pipeline_run_ctrl: budget, halt/resume, step,
// masking/clear, reset mid-run, and saturation on a narrow-counter instance.
module tb_pipeline_run_ctrl;
    import cpu_ctrl_pkg::*;

    typedef struct packed {
        logic       run;
        logic       done;
        logic [1:0] st;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0, start = 1'b0, step = 1'b0, halt = 1'b0, clr = 1'b0, stall = 1'b0, flush = 1'b0;
    logic run, done, limit;
    logic [1:0] state;
    logic [31:0] ccnt, scnt, fcnt;

    logic s_rst = 1'b0, s_start = 1'b0, s_stall = 1'b0;
    logic s_run, s_done, s_limit;
    logic [1:0] s_state;
    logic [2:0] s_ccnt, s_scnt, s_fcnt;

    int n_pass = 0;
    int n_total = 0;
    exp_t sb_q[$];

    pipeline_run_ctrl #(.CNT_W(32), .MAX_CYCLES(30)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .step_i(step), .halt_req_i(halt),
        .clear_i(clr), .stall_i(stall), .flush_i(flush), .run_o(run), .state_o(state),
        .done_o(done), .limit_o(limit), .cycle_cnt_o(ccnt), .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
    );

    pipeline_run_ctrl #(.CNT_W(3), .MAX_CYCLES(0)) dut_sat (
        .clk_i(clk), .rst_i(s_rst), .start_i(s_start), .step_i(1'b0), .halt_req_i(1'b0),
        .clear_i(1'b0), .stall_i(s_stall), .flush_i(1'b0), .run_o(s_run), .state_o(s_state),
        .done_o(s_done), .limit_o(s_limit), .cycle_cnt_o(s_ccnt), .stall_cnt_o(s_scnt), .flush_cnt_o(s_fcnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; s_rst = 1'b0;
        tick(); tick();
        rst = 1'b1; s_rst = 1'b1;
        n_total++;
        if ({state, run, done, limit} !== 5'b0)
            $display("FAIL reset_flags: got st=%0d run=%0d done=%0d lim=%0d, want all 0", state, run, done, limit);
        else n_pass++;
        n_total++;
        if ({ccnt, scnt, fcnt} !== 96'b0)
            $display("FAIL reset_cnts: got %0d/%0d/%0d, want 0/0/0", ccnt, scnt, fcnt);
        else n_pass++;
    endtask

    task automatic test_budget();
        int runs = 0;
        int dones = 0;
        exp_t e;
        start = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            sb_q.push_back('{run: (i <= 30), done: (i == 31), st: (i <= 30) ? ST_RUN : ST_HALT});
            stall = (i - 1 == 3) || (i - 1 == 4);
            flush = (i - 1 == 10);
            tick();
            e = sb_q.pop_front();
            runs += int'(run);
            dones += int'(done);
            n_total++;
            if ({run, done, state} !== {e.run, e.done, e.st})
                $display("FAIL budget_cyc%0d: got run=%0d done=%0d st=%0d, want run=%0d done=%0d st=%0d",
                         i, run, done, state, e.run, e.done, e.st);
            else n_pass++;
        end
        stall = 1'b0; flush = 1'b0;
        n_total++;
        if (runs != 30 || dones != 1)
            $display("FAIL budget_pulses: got run=%0d done=%0d, want 30/1", runs, dones);
        else n_pass++;
        n_total++;
        if (ccnt !== 30 || scnt !== 2 || fcnt !== 1 || limit !== 1'b1)
            $display("FAIL budget_cnts: got %0d/%0d/%0d lim=%0d, want 30/2/1 lim=1", ccnt, scnt, fcnt, limit);
        else n_pass++;
        tick(); tick(); tick();
        n_total++;
        if (state !== ST_HALT || run !== 1'b0 || ccnt !== 30)
            $display("FAIL budget_sticky: got st=%0d run=%0d cyc=%0d, want 3/0/30", state, run, ccnt);
        else n_pass++;
        start = 1'b0;
    endtask

    task automatic test_mask_clear();
        stall = 1'b1; flush = 1'b1;
        tick(); tick(); tick();
        n_total++;
        if (ccnt !== 30 || scnt !== 2 || fcnt !== 1)
            $display("FAIL mask_halt: got %0d/%0d/%0d, want 30/2/1", ccnt, scnt, fcnt);
        else n_pass++;
        clr = 1'b1; tick(); clr = 1'b0;
        n_total++;
        if (state !== ST_IDLE || limit !== 1'b0 || ccnt !== 0 || scnt !== 0 || fcnt !== 0)
            $display("FAIL clear_halt: got st=%0d lim=%0d %0d/%0d/%0d, want 0/0 0/0/0", state, limit, ccnt, scnt, fcnt);
        else n_pass++;
        tick(); tick(); tick();
        n_total++;
        if (state !== ST_IDLE || ccnt !== 0 || scnt !== 0 || fcnt !== 0)
            $display("FAIL mask_idle: got st=%0d %0d/%0d/%0d, want 0 0/0/0", state, ccnt, scnt, fcnt);
        else n_pass++;
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_halt_resume();
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick(); tick();
        halt = 1'b1; tick(); halt = 1'b0;
        n_total++;
        if (state !== ST_HALT || run !== 1'b0 || done !== 1'b1 || ccnt !== 5)
            $display("FAIL halt_req: got st=%0d run=%0d done=%0d cyc=%0d, want 3/0/1/5", state, run, done, ccnt);
        else n_pass++;
        start = 1'b1; tick(); start = 1'b0;
        n_total++;
        if (state !== ST_RUN || run !== 1'b1 || ccnt !== 5)
            $display("FAIL resume: got st=%0d run=%0d cyc=%0d, want 1/1/5", state, run, ccnt);
        else n_pass++;
        tick();
        clr = 1'b1; tick(); clr = 1'b0;
        n_total++;
        if (state !== ST_RUN || ccnt !== 7)
            $display("FAIL clear_in_run: got st=%0d cyc=%0d, want 1/7", state, ccnt);
        else n_pass++;
        halt = 1'b1; tick(); halt = 1'b0;
        clr = 1'b1; tick(); clr = 1'b0;
        n_total++;
        if (state !== ST_IDLE || ccnt !== 0)
            $display("FAIL clear_after_resume: got st=%0d cyc=%0d, want 0/0", state, ccnt);
        else n_pass++;
    endtask

    task automatic test_step();
        int runs = 0;
        int dones = 0;
        exp_t e;
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 3; c++) begin
                step = (c == 0);
                sb_q.push_back('{run: (c == 0), done: (c == 1), st: (c == 0) ? ST_STEP : ST_HALT});
                tick();
                e = sb_q.pop_front();
                runs += int'(run);
                dones += int'(done);
                n_total++;
                if ({run, done, state} !== {e.run, e.done, e.st})
                    $display("FAIL step%0d_c%0d: got run=%0d done=%0d st=%0d, want run=%0d done=%0d st=%0d",
                             p, c, run, done, state, e.run, e.done, e.st);
                else n_pass++;
            end
        end
        step = 1'b0;
        n_total++;
        if (ccnt !== 3 || runs != 3 || dones != 3)
            $display("FAIL step_totals: got cyc=%0d run=%0d done=%0d, want 3/3/3", ccnt, runs, dones);
        else n_pass++;
        clr = 1'b1; tick(); clr = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        start = 1'b1; step = 1'b1; tick(); step = 1'b0;
        n_total++;
        if (state !== ST_RUN)
            $display("FAIL start_step_prio: got st=%0d, want 1", state);
        else n_pass++;
        stall = 1'b1; flush = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0; tick(); rst = 1'b1;
        n_total++;
        if ({state, run, done, limit} !== 5'b0 || {ccnt, scnt, fcnt} !== 96'b0)
            $display("FAIL reset_mid_run: got st=%0d run=%0d %0d/%0d/%0d, want all 0", state, run, ccnt, scnt, fcnt);
        else n_pass++;
        start = 1'b0; stall = 1'b0; flush = 1'b0;
        tick();
        n_total++;
        if (state !== ST_IDLE || run !== 1'b0)
            $display("FAIL post_reset_idle: got st=%0d run=%0d, want 0/0", state, run);
        else n_pass++;
    endtask

    task automatic test_saturation();
        s_start = 1'b1; s_stall = 1'b1; tick(); s_start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        n_total++;
        if (s_ccnt !== 3'd7 || s_scnt !== 3'd7 || s_fcnt !== 3'd0)
            $display("FAIL saturate: got %0d/%0d/%0d, want 7/7/0", s_ccnt, s_scnt, s_fcnt);
        else n_pass++;
        n_total++;
        if (s_run !== 1'b1 || s_limit !== 1'b0 || s_state !== ST_RUN)
            $display("FAIL unlimited: got run=%0d lim=%0d st=%0d, want 1/0/1", s_run, s_limit, s_state);
        else n_pass++;
        s_stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_budget();
        test_mask_clear();
        test_halt_resume();
        test_step();
        test_reset_mid_run();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
